arrhythmia_frame_sequencer: RTL and testbench

//  Frame-level scheduler for the arrhythmia VAE classifier datapath (enc_1 -> softplus -> enc_2 mean/var
//  -> lambda -> enc_3 -> softplus -> enc_4 -> sigmoid). Accepts one 10-element input frame over a

---
 rtl/arrhythmia_frame_sequencer.sv | 155 +++++++++++++++
 tb/tb_arrhythmia_frame_sequencer.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/arrhythmia_frame_sequencer.sv
// Frame-level scheduler for the arrhythmia VAE classifier datapath: latches one input frame,
// walks the per-layer clear lines through fixed cycle budgets and buffers the 2-element result.
module arrhythmia_frame_sequencer #(
  parameter int BITSIZE   = 16,
  parameter int ENC1_CC   = 12,
  parameter int SP1_CC    = 4,
  parameter int ENC2_CC   = 8,
  parameter int LAMBDA_CC = 10,
  parameter int ENC3_CC   = 4,
  parameter int SP3_CC    = 4,
  parameter int ENC4_CC   = 8,
  parameter int SIG_CC    = 4,
  parameter int CNT_W     = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [BITSIZE*10-1:0] x_in,
  output logic [BITSIZE*10-1:0] x_hold,
  output logic                  enc1_start,
  output logic                  enc2_start,
  output logic                  enc3_start,
  output logic                  enc4_start,
  input  logic [BITSIZE*2-1:0]  dp_y,
  output logic [BITSIZE*2-1:0]  y_out,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  busy,
  output logic [3:0]            stage,
  output logic [15:0]           frame_cnt
);

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_ENC1   = 4'd1,
    S_SP1    = 4'd2,
    S_ENC2   = 4'd3,
    S_LAMBDA = 4'd4,
    S_ENC3   = 4'd5,
    S_SP3    = 4'd6,
    S_ENC4   = 4'd7,
    S_SIG    = 4'd8,
    S_HOLD   = 4'd9
  } state_t;

  // A budget of 0 is treated as 1 so every timed state lasts at least one cycle.
  function automatic logic [CNT_W-1:0] ld(input int cc);
    if (cc <= 1) return '0;
    return CNT_W'(cc - 1);
  endfunction

  function automatic logic [CNT_W-1:0] load_for(input state_t s);
    case (s)
      S_ENC1:   return ld(ENC1_CC);
      S_SP1:    return ld(SP1_CC);
      S_ENC2:   return ld(ENC2_CC);
      S_LAMBDA: return ld(LAMBDA_CC);
      S_ENC3:   return ld(ENC3_CC);
      S_SP3:    return ld(SP3_CC);
      S_ENC4:   return ld(ENC4_CC);
      S_SIG:    return ld(SIG_CC);
      default:  return '0;
    endcase
  endfunction

  state_t                 state_reg, state_next;
  logic [CNT_W-1:0]       cnt_reg, cnt_next;
  logic [BITSIZE*10-1:0]  x_hold_reg, x_hold_next;
  logic [BITSIZE*2-1:0]   y_out_reg, y_out_next;
  logic                   out_valid_reg, out_valid_next;
  logic [15:0]            frame_cnt_reg, frame_cnt_next;
  logic [3:0]             start_reg, start_next;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg     <= S_IDLE;
      cnt_reg       <= '0;
      x_hold_reg    <= '0;
      y_out_reg     <= '0;
      out_valid_reg <= 1'b0;
      frame_cnt_reg <= '0;
      start_reg     <= 4'hF;
    end else begin
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      x_hold_reg    <= x_hold_next;
      y_out_reg     <= y_out_next;
      out_valid_reg <= out_valid_next;
      frame_cnt_reg <= frame_cnt_next;
      start_reg     <= start_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    cnt_next       = cnt_reg;
    x_hold_next    = x_hold_reg;
    y_out_next     = y_out_reg;
    out_valid_next = out_valid_reg;
    frame_cnt_next = frame_cnt_reg;
    start_next     = start_reg;
    case (state_reg)
      S_IDLE: begin
        if (in_valid) begin
          state_next    = S_ENC1;
          cnt_next      = load_for(S_ENC1);
          x_hold_next   = x_in;
          start_next[0] = 1'b0;
        end
      end
      S_ENC1, S_SP1, S_ENC2, S_LAMBDA, S_ENC3, S_SP3, S_ENC4, S_SIG: begin
        if (cnt_reg == '0) begin
          state_next = state_t'(state_reg + 4'd1);
          cnt_next   = load_for(state_next);
          // The result is sampled exactly once, on the SIG->HOLD edge.
          if (state_reg == S_SIG) begin
            y_out_next     = dp_y;
            out_valid_next = 1'b1;
          end
          if (state_next == S_ENC2) start_next[1] = 1'b0;
          if (state_next == S_ENC3) start_next[2] = 1'b0;
          if (state_next == S_ENC4) start_next[3] = 1'b0;
        end else begin
          cnt_next = cnt_reg - CNT_W'(1);
        end
      end
      S_HOLD: begin
        if (out_valid_reg && out_ready) begin
          state_next     = S_IDLE;
          out_valid_next = 1'b0;
          frame_cnt_next = frame_cnt_reg + 16'd1;
          start_next     = 4'hF;
        end
      end
      default: begin
        state_next = S_IDLE;
        start_next = 4'hF;
      end
    endcase
  end

  assign in_ready   = (state_reg == S_IDLE);
  assign busy       = (state_reg != S_IDLE);
  assign stage      = state_reg;
  assign x_hold     = x_hold_reg;
  assign y_out      = y_out_reg;
  assign out_valid  = out_valid_reg;
  assign frame_cnt  = frame_cnt_reg;
  assign enc1_start = start_reg[0];
  assign enc2_start = start_reg[1];
  assign enc3_start = start_reg[2];
  assign enc4_start = start_reg[3];

endmodule

// File: tb/tb_arrhythmia_frame_sequencer.sv
// Bench for arrhythmia_frame_sequencer: directed scenarios plus randomized traffic,
// all checked every cycle against an elapsed-time model of the frame schedule.
module tb_arrhythmia_frame_sequencer;

  localparam int BITSIZE = 16;

  // Stage budgets, with 0 treated as 1.
  function automatic int dur(input int i);
    int cc;
    case (i)
      0: cc = 12;
      1: cc = 4;
      2: cc = 8;
      3: cc = 10;
      4: cc = 4;
      5: cc = 4;
      6: cc = 8;
      default: cc = 4;
    endcase
    return (cc < 1) ? 1 : cc;
  endfunction

  function automatic int bound(input int n);
    int b = 0;
    for (int i = 0; i < n; i++) b += dur(i);
    return b;
  endfunction

  localparam int SUM = 54;

  logic                  clk;
  logic                  reset;
  logic                  in_valid;
  logic                  in_ready;
  logic [BITSIZE*10-1:0] x_in;
  logic [BITSIZE*10-1:0] x_hold;
  logic                  enc1_start, enc2_start, enc3_start, enc4_start;
  logic [BITSIZE*2-1:0]  dp_y;
  logic [BITSIZE*2-1:0]  y_out;
  logic                  out_valid;
  logic                  out_ready;
  logic                  busy;
  logic [3:0]            stage;
  logic [15:0]           frame_cnt;

  arrhythmia_frame_sequencer dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .x_in(x_in), .x_hold(x_hold), .enc1_start(enc1_start), .enc2_start(enc2_start),
    .enc3_start(enc3_start), .enc4_start(enc4_start), .dp_y(dp_y), .y_out(y_out),
    .out_valid(out_valid), .out_ready(out_ready), .busy(busy), .stage(stage),
    .frame_cnt(frame_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  logic cmp_en = 1'b0;

  task automatic chk(input string nm, input logic [159:0] act, input logic [159:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Model: a frame is described only by edges elapsed since its accept edge.
  logic                  m_idle, m_hold, m_valid;
  int                    m_e;
  logic [BITSIZE*10-1:0] m_x;
  logic [BITSIZE*2-1:0]  m_y;
  logic [15:0]           m_fc;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_idle <= 1'b1; m_hold <= 1'b0; m_valid <= 1'b0; m_e <= 0;
      m_x <= '0; m_y <= '0; m_fc <= '0;
    end else if (m_idle) begin
      if (in_valid) begin
        m_idle <= 1'b0; m_e <= 0; m_x <= x_in;
      end
    end else if (!m_hold) begin
      m_e <= m_e + 1;
      if (m_e + 1 == SUM) begin
        m_hold <= 1'b1; m_y <= dp_y; m_valid <= 1'b1;
      end
    end else if (out_ready) begin
      m_valid <= 1'b0; m_fc <= m_fc + 16'd1; m_idle <= 1'b1; m_hold <= 1'b0;
    end
  end

  function automatic int exp_stage(input logic idle, input logic hold, input int e);
    if (idle) return 0;
    if (hold) return 9;
    for (int s = 1; s <= 8; s++) if (e < bound(s)) return s;
    return 9;
  endfunction

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("stage", stage, exp_stage(m_idle, m_hold, m_e));
      chk("in_ready", in_ready, m_idle);
      chk("busy", busy, !m_idle);
      chk("enc1_start", enc1_start, m_idle);
      chk("enc2_start", enc2_start, m_idle || (!m_hold && m_e < bound(2)));
      chk("enc3_start", enc3_start, m_idle || (!m_hold && m_e < bound(4)));
      chk("enc4_start", enc4_start, m_idle || (!m_hold && m_e < bound(6)));
      chk("out_valid", out_valid, m_valid);
      chk("y_out", y_out, m_y);
      chk("x_hold", x_hold, m_x);
      chk("frame_cnt", frame_cnt, m_fc);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [159:0] frame_a;
  logic [159:0] frame_b;
  int rise[3];
  int nrise;
  logic prev_v;

  initial begin
    frame_a = {10{16'h0100}};
    frame_b = {10{16'h7E57}};
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; x_in = '0; dp_y = '0;

    // Asynchronous reset off the clock edge.
    #3 reset = 1'b0;
    #1;
    chk("rst_stage", stage, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_starts", {enc4_start, enc3_start, enc2_start, enc1_start}, 4'hF);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_frame_cnt", frame_cnt, 0);
    cmp_en = 1'b1;
    tick(); tick();
    reset = 1'b1;
    tick();

    // One frame with pinned schedule points and an ignored mid-frame in_valid.
    x_in = frame_a; dp_y = 32'h00AB_0155; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("k_enc1", enc1_start, 0);
    chk("k_stage", stage, 1);
    for (int i = 1; i <= 54; i++) begin
      tick();
      if (i == 9) begin in_valid = 1'b1; x_in = frame_b; end
      if (i == 10) begin in_valid = 1'b0; chk("busy_x_hold", x_hold, frame_a); end
      if (i == 15) chk("enc2_k15", enc2_start, 1);
      if (i == 16) chk("enc2_k16", enc2_start, 0);
      if (i == 33) chk("enc3_k33", enc3_start, 1);
      if (i == 34) chk("enc3_k34", enc3_start, 0);
      if (i == 41) chk("enc4_k41", enc4_start, 1);
      if (i == 42) chk("enc4_k42", enc4_start, 0);
      if (i == 53) chk("valid_k53", out_valid, 0);
      if (i == 54) begin
        chk("valid_k54", out_valid, 1);
        chk("y_k54", y_out, 32'h00AB_0155);
      end
    end

    // Consumer stalls for 20 cycles while dp_y moves.
    for (int i = 0; i < 20; i++) begin
      dp_y = $urandom();
      tick();
    end
    chk("stall_y", y_out, 32'h00AB_0155);
    chk("stall_stage", stage, 9);
    chk("stall_in_ready", in_ready, 0);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("rel_stage", stage, 0);
    chk("rel_frame_cnt", frame_cnt, 1);
    chk("rel_x_hold", x_hold, frame_a);

    // Reset during LAMBDA aborts the frame.
    x_in = frame_b; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (30) tick();
    chk("abort_pre_stage", stage, 4);
    reset = 1'b0;
    #1;
    chk("abort_stage", stage, 0);
    chk("abort_valid", out_valid, 0);
    chk("abort_frame_cnt", frame_cnt, 0);
    tick();
    reset = 1'b1;
    tick();

    // Back-to-back frames.
    in_valid = 1'b1; out_ready = 1'b1;
    nrise = 0; prev_v = 1'b0;
    for (int i = 0; i <= 167; i++) begin
      tick();
      if (out_valid && !prev_v && nrise < 3) begin rise[nrise] = i; nrise++; end
      prev_v = out_valid;
      if (i == 167) begin
        in_valid = 1'b0;
        chk("b2b_frame_cnt", frame_cnt, 3);
      end
    end
    chk("b2b_nrise", nrise, 3);
    if (nrise == 3) begin
      chk("b2b_rise0", rise[0], 54);
      chk("b2b_rise1", rise[1], 110);
      chk("b2b_rise2", rise[2], 166);
    end
    out_ready = 1'b0;
    tick();

    // Randomized traffic with occasional resets.
    for (int c = 0; c < 3000; c++) begin
      in_valid = ($urandom_range(0, 1) == 1);
      out_ready = ($urandom_range(0, 2) == 0);
      for (int w = 0; w < 5; w++) x_in[w*32 +: 32] = $urandom();
      dp_y = $urandom();
      if (!reset) reset = 1'b1;
      else if ($urandom_range(0, 499) == 0) reset = 1'b0;
      tick();
    end
    reset = 1'b1;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
